dut_stream_arbiter: RTL and testbench
=====================================

Name: dut_stream_arbiter

Overview:
- Shares the 32-bit streaming `dut` (clk, enable, din, dout, valid) between two requesters.
- Round-robin arbitrates word requests and drives single-cycle `enable` pulses with a guaranteed idle gap.
- Tags each issued word with its requester and routes each returned `valid`/`dout` to the owning requester in issue order.
- Sits directly in front of `dut` in the top level; replaces hand-sequenced enable pulses.

Parameters:
- MAX_INFLIGHT, 4: maximum words issued to dut without a returned valid (power of 2, ≥2).
- ISSUE_GAP, 2: cycles from one enable pulse to the earliest cycle a new word may be accepted (≥1).
- TIMEOUT, 64: cycles the oldest in-flight word may wait for valid before timeout_err sets.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  32  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
- req1_valid  in  1  requester 1 has a word
- req1_data  in  32  requester 1 word
- req1_ready  out  1  requester 1 accept
- dut_enable  out  1  to dut enable
- dut_din  out  32  to dut din
- dut_dout  in  32  from dut dout
- dut_valid  in  1  from dut valid
- rsp_data  out  32  returned word
- rsp0_valid  out  1  rsp_data belongs to requester 0
- rsp1_valid  out  1  rsp_data belongs to requester 1
- inflight  out  $clog2(MAX_INFLIGHT)+1  words outstanding
- clear_err  in  1  synchronous clear of sticky errors
- timeout_err  out  1  sticky timeout
- spurious_err  out  1  sticky: dut_valid with nothing in flight

Behaviour:
- Reset (n_rst low, async): state ARB; all outputs 0; tag FIFO empty; last_grant=1, so requester 0 wins first; gap and timeout counters 0.
- FSM ARB → ISSUE → GAP → ARB.
  - ARB: grant when any reqN_valid, inflight<MAX_INFLIGHT, and not in GAP.
  - Round-robin: when both are valid, grant the requester not in last_grant. A single valid requester is granted regardless.
  - reqN_ready is combinational, high only for the granted requester in ARB.
- Acceptance edge (valid&ready):
  - register data into dut_din;
  - push requester id into the tag FIFO;
  - update last_grant;
  - go to ISSUE.
- ISSUE (exactly 1 cycle): dut_enable=1; dut_din = accepted word.
- GAP (ISSUE_GAP-1 cycles; skipped if ISSUE_GAP=1): dut_enable=0; dut_din holds its value until the next acceptance.
- Minimum issue period: ISSUE_GAP+1 cycles. Default is 3: enable high 1 of 3 cycles.
- Return path:
  - On dut_valid with the tag FIFO non-empty: pop the tag.
  - Next cycle: rsp_data=dut_dout and rsp{tag}_valid=1 for one cycle. Latency is 1 cycle, registered.
  - No backpressure on responses.
- dut_valid with the FIFO empty: drop the word; spurious_err=1 (sticky).
- Push and pop on the same edge: inflight unchanged; the FIFO handles it correctly, including when full.
- inflight = FIFO occupancy. At MAX_INFLIGHT both readies are held 0.
- Timeout counter:
  - counts while inflight>0; resets on every pop and whenever inflight=0;
  - reaching TIMEOUT sets timeout_err (sticky);
  - in-flight state is NOT flushed; issue continues normally.
- clear_err=1 clears both sticky errors on the next edge. A set event in the same cycle wins over clear.
- Reset mid-operation: everything is flushed. Results the dut delivers after reset are therefore reported as spurious.

Decomposition:
- Package dut_arb_pkg:
  - state_t enum {ARB, ISSUE, GAP};
  - req_id_t (1 bit);
  - constant NUM_REQ=2.
- Sub-module dut_tag_fifo: MAX_INFLIGHT-deep × 1-bit synchronous FIFO with push, pop, count, full, empty; async active-low n_rst.

Test Plan:
- Single word: req0 0x1234ABCD, dut returns 0x1234ABCD 4 cycles after enable → rsp0_valid 1 cycle after dut_valid with rsp_data=0x1234ABCD; rsp1_valid stays 0.
- Both requesters continuously valid (req0 0xA0000000+n, req1 0xB0000000+n) → grants alternate 0,1,0,1 starting with 0; dut_enable pulses exactly every 3 cycles; responses are routed to their owners in issue order.
- dut stalled (no valid) with both requesters valid → exactly 4 enables, then readies 0 and inflight=4. One dut_valid → inflight 3, one further issue after the FSM gap.
- Return timed on the same cycle as an acceptance at inflight=4 → acceptance blocked that cycle; at inflight=3 → inflight remains 3.
- dut_valid with inflight=0 → spurious_err=1, no rsp valid. clear_err → 0 next cycle.
- Issue one word, no return for 64 cycles → timeout_err=1 at cycle 64. Assert n_rst mid-stream → all outputs 0 asynchronously; a later dut_valid sets spurious_err.

Source files
------------

// File: rtl/dut_arb_pkg.sv
// Shared types for the two-requester stream arbiter in front of the 32-bit dut.
package dut_arb_pkg;

  typedef enum logic [1:0] {ARB, ISSUE, GAP} state_t;

  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/dut_tag_fifo.sv
// Requester-id FIFO: one entry per word issued to dut, popped as results return.
module dut_tag_fifo
  import dut_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  pop_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  req_id_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);
  assign pop_id  = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/dut_stream_arbiter.sv
// Round-robin arbiter issuing paced enable pulses to dut and routing results back by tag.
//   state | meaning
//   ARB   | waiting to grant a requester word
//   ISSUE | dut_enable high for the accepted word
//   GAP   | idle spacing before the next grant
module dut_stream_arbiter
  import dut_arb_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int ISSUE_GAP    = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            req0_valid,
  input  logic [31:0]                     req0_data,
  output logic                            req0_ready,
  input  logic                            req1_valid,
  input  logic [31:0]                     req1_data,
  output logic                            req1_ready,
  output logic                            dut_enable,
  output logic [31:0]                     dut_din,
  input  logic [31:0]                     dut_dout,
  input  logic                            dut_valid,
  output logic [31:0]                     rsp_data,
  output logic                            rsp0_valid,
  output logic                            rsp1_valid,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  input  logic                            clear_err,
  output logic                            timeout_err,
  output logic                            spurious_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

  state_t               state, state_nxt;
  req_id_t              last_grant, grant_id, pop_id;
  logic [NUM_REQ-1:0]   req_vec;
  logic                 accept, full, empty, pop, spurious, tmo_hit;
  logic [GW-1:0]        gap_cnt;
  logic [TW-1:0]        tmo_cnt;

  assign req_vec = {req1_valid, req0_valid};

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    grant_id   = 1'b0;
    case (state)
      ARB: begin
        // Readies are forced low while reset is held so every output reads 0.
        if (n_rst && (|req_vec) && !full) begin
          accept    = 1'b1;
          grant_id  = (&req_vec) ? ~last_grant : req1_valid;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = (ISSUE_GAP > 1) ? GAP : ARB;
      GAP:     if (gap_cnt == '0) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  assign req0_ready = accept & (grant_id == 1'b0);
  assign req1_ready = accept & (grant_id == 1'b1);
  assign dut_enable = (state == ISSUE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ARB;
      last_grant <= 1'b1;
      dut_din    <= '0;
      gap_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dut_din    <= grant_id ? req1_data : req0_data;
        last_grant <= grant_id;
      end
      if (state == ISSUE)
        gap_cnt <= GW'(ISSUE_GAP > 1 ? ISSUE_GAP - 2 : 0);
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

  assign pop      = dut_valid & ~empty;
  assign spurious = dut_valid & empty;

  dut_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .pop_id  (pop_id),
    .count   (inflight),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= pop & (pop_id == 1'b0);
      rsp1_valid <= pop & (pop_id == 1'b1);
      if (pop) rsp_data <= dut_dout;
    end
  end

  // Age of the oldest in-flight word; saturates so the flag stays a single event.
  assign tmo_hit = ~pop && (inflight != '0) && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt      <= '0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      if (pop || inflight == '0)
        tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT))
        tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit)        timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (spurious)       spurious_err <= 1'b1;
      else if (clear_err) spurious_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dut_stream_arbiter.sv
// Directed bench for dut_stream_arbiter: grants, pacing, return routing, errors and reset.
module tb_dut_stream_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        dut_enable, dut_valid;
  logic [31:0] dut_din, dut_dout, rsp_data;
  logic        rsp0_valid, rsp1_valid;
  logic [2:0]  inflight;
  logic        clear_err, timeout_err, spurious_err;

  logic        auto_dut, man_valid;
  logic [31:0] man_dout;
  logic [3:0]  pv = '0;
  logic [31:0] pd [4];
  logic [32:0] q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Loopback model of dut: echoes din four cycles after its enable.
  always @(posedge clk) begin
    pv    <= {pv[2:0], dut_enable};
    pd[0] <= dut_din;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  assign dut_valid = auto_dut ? pv[3] : man_valid;
  assign dut_dout  = auto_dut ? pd[3] : man_dout;

  dut_stream_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dut_enable(dut_enable), .dut_din(dut_din), .dut_dout(dut_dout), .dut_valid(dut_valid),
    .rsp_data(rsp_data), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .inflight(inflight), .clear_err(clear_err),
    .timeout_err(timeout_err), .spurious_err(spurious_err)
  );

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    man_valid = 1'b0; clear_err = 1'b0; auto_dut = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    man_valid = 1'b0; man_dout = '0; clear_err = 1'b0; auto_dut = 1'b0;
    nclk(2);
    vectors++;
    if ({dut_enable, dut_din, req0_ready, req1_ready, rsp_data, rsp0_valid, rsp1_valid,
         inflight, timeout_err, spurious_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: en=%b din=%h rdy=%b%b rsp=%h v=%b%b infl=%0d err=%b%b",
               dut_enable, dut_din, req0_ready, req1_ready, rsp_data, rsp0_valid, rsp1_valid,
               inflight, timeout_err, spurious_err);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h1234ABCD; #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    nclk(1); req0_valid = 1'b0;
    vectors++;
    if ({dut_enable, dut_din, inflight} !== {1'b1, 32'h1234ABCD, 3'd1}) begin
      miscompares++;
      $display("FAIL single_issue: en=%b din=%h infl=%0d want 1 1234abcd 1", dut_enable, dut_din, inflight);
    end
    nclk(1);
    vectors++;
    if ({dut_enable, dut_din} !== {1'b0, 32'h1234ABCD}) begin
      miscompares++; $display("FAIL single_gap: en=%b din=%h want 0 1234abcd", dut_enable, dut_din);
    end
    nclk(3); man_valid = 1'b1; man_dout = 32'h1234ABCD;
    nclk(1); man_valid = 1'b0;
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp_data, inflight} !== {2'b10, 32'h1234ABCD, 3'd0}) begin
      miscompares++;
      $display("FAIL single_rsp: v=%b%b data=%h infl=%0d want 10 1234abcd 0",
               rsp0_valid, rsp1_valid, rsp_data, inflight);
    end
    nclk(1);
    vectors++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      miscompares++; $display("FAIL single_rsp_pulse: v=%b%b want 00", rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic test_round_robin();
    int n0, n1, last_en;
    logic exp_grant, acc0, acc1;
    logic [32:0] e;
    do_reset();
    auto_dut = 1'b1; q.delete();
    n0 = 0; n1 = 0; last_en = -1; exp_grant = 1'b0;
    req0_data = 32'hA0000000; req1_data = 32'hB0000000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 42; c++) begin
      if (c == 30) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      acc0 = req0_ready; acc1 = req1_ready;
      if (acc0 || acc1) begin
        vectors++;
        if (acc1 !== exp_grant || (acc0 && acc1)) begin
          miscompares++; $display("FAIL rr_grant: got r0=%b r1=%b want id %0d", acc0, acc1, exp_grant);
        end
        q.push_back({acc1, acc1 ? req1_data : req0_data});
        exp_grant = ~exp_grant;
      end
      if (dut_enable) begin
        if (last_en >= 0) begin
          vectors++;
          if (c - last_en != 3) begin
            miscompares++; $display("FAIL rr_enable_period: got %0d want 3", c - last_en);
          end
        end
        last_en = c;
      end
      if (rsp0_valid || rsp1_valid) begin
        vectors++;
        e = (q.size() != 0) ? q.pop_front() : 33'h0;
        if ({rsp1_valid, rsp0_valid, rsp_data} !== {e[32], ~e[32], e[31:0]}) begin
          miscompares++;
          $display("FAIL rr_rsp: got v1=%b v0=%b data=%h want owner %0d data %h",
                   rsp1_valid, rsp0_valid, rsp_data, e[32], e[31:0]);
        end
      end
      @(negedge clk);
      if (acc0) begin n0++; req0_data = 32'hA0000000 + 32'(n0); end
      if (acc1) begin n1++; req1_data = 32'hB0000000 + 32'(n1); end
    end
    vectors++;
    if (q.size() != 0 || inflight !== 3'd0 || n0 + n1 < 9) begin
      miscompares++;
      $display("FAIL rr_drain: pending=%0d infl=%0d grants=%0d want 0 0 >=9", q.size(), inflight, n0 + n1);
    end
    auto_dut = 1'b0;
  endtask

  task automatic test_stall();
    int en_cnt;
    do_reset();
    req0_data = 32'hA0000000; req1_data = 32'hB0000000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    en_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      nclk(1);
      if (dut_enable) en_cnt++;
    end
    #1;
    vectors++;
    if (en_cnt != 4 || {req0_ready, req1_ready} !== 2'b00 || inflight !== 3'd4) begin
      miscompares++;
      $display("FAIL stall_full: enables=%0d rdy=%b%b infl=%0d want 4 00 4", en_cnt, req0_ready, req1_ready, inflight);
    end
    man_valid = 1'b1; man_dout = 32'h11111111; #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL stall_block_at_full: rdy=%b%b want 00", req0_ready, req1_ready);
    end
    nclk(1); man_dout = 32'h22222222; #1;
    vectors++;
    if ({inflight, rsp0_valid, rsp1_valid, rsp_data, req0_ready, req1_ready} !==
        {3'd3, 2'b10, 32'h11111111, 2'b10}) begin
      miscompares++;
      $display("FAIL stall_pop: infl=%0d v=%b%b data=%h rdy=%b%b want 3 10 11111111 10",
               inflight, rsp0_valid, rsp1_valid, rsp_data, req0_ready, req1_ready);
    end
    nclk(1); man_valid = 1'b0;
    vectors++;
    if ({inflight, rsp0_valid, rsp1_valid, rsp_data, dut_enable, dut_din} !==
        {3'd3, 2'b01, 32'h22222222, 1'b1, 32'hA0000000}) begin
      miscompares++;
      $display("FAIL stall_push_pop: infl=%0d v=%b%b data=%h en=%b din=%h want 3 01 22222222 1 a0000000",
               inflight, rsp0_valid, rsp1_valid, rsp_data, dut_enable, dut_din);
    end
    nclk(3);
    vectors++;
    if ({inflight, dut_enable, dut_din} !== {3'd4, 1'b1, 32'hB0000000}) begin
      miscompares++;
      $display("FAIL stall_refill: infl=%0d en=%b din=%h want 4 1 b0000000", inflight, dut_enable, dut_din);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    man_valid = 1'b1; man_dout = 32'hDEADBEEF;
    nclk(1); man_valid = 1'b0;
    vectors++;
    if ({spurious_err, rsp0_valid, rsp1_valid, inflight} !== {3'b100, 3'd0}) begin
      miscompares++;
      $display("FAIL spurious_set: err=%b v=%b%b infl=%0d want 1 00 0", spurious_err, rsp0_valid, rsp1_valid, inflight);
    end
    clear_err = 1'b1;
    nclk(1); clear_err = 1'b0;
    vectors++;
    if (spurious_err !== 1'b0) begin
      miscompares++; $display("FAIL spurious_clear: err=%b want 0", spurious_err);
    end
    man_valid = 1'b1; clear_err = 1'b1;
    nclk(1); man_valid = 1'b0; clear_err = 1'b0;
    vectors++;
    if (spurious_err !== 1'b1) begin
      miscompares++; $display("FAIL spurious_set_beats_clear: err=%b want 1", spurious_err);
    end
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h00000055;
    nclk(1); req0_valid = 1'b0;
    vectors++;
    if (inflight !== 3'd1) begin
      miscompares++; $display("FAIL timeout_issue: infl=%0d want 1", inflight);
    end
    nclk(63);
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_early: err=%b want 0", timeout_err);
    end
    nclk(1);
    vectors++;
    if ({timeout_err, inflight} !== {1'b1, 3'd1}) begin
      miscompares++; $display("FAIL timeout_set: err=%b infl=%0d want 1 1", timeout_err, inflight);
    end
    #2; req1_valid = 1'b1; n_rst = 1'b0; #1;
    vectors++;
    if ({dut_enable, dut_din, req0_ready, req1_ready, rsp_data, rsp0_valid, rsp1_valid,
         inflight, timeout_err, spurious_err} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: en=%b din=%h rdy=%b%b infl=%0d err=%b%b",
               dut_enable, dut_din, req0_ready, req1_ready, inflight, timeout_err, spurious_err);
    end
    @(negedge clk); n_rst = 1'b1; req1_valid = 1'b0; man_valid = 1'b1; man_dout = 32'h00000055;
    nclk(1); man_valid = 1'b0;
    vectors++;
    if ({spurious_err, rsp0_valid, rsp1_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset_spurious: err=%b v=%b%b want 1 00", spurious_err, rsp0_valid, rsp1_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_spurious();
    test_timeout_and_reset();
    nclk(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
